// File: rtl/uart_rx_if.sv
// Serial receive bus: the raw line and shared baud tick in, the recovered word and status out.
interface uart_rx_if;
    logic       rx_i;
    logic       sample_tick_i;
    logic [7:0] dout_o;
    logic       rx_done_tick_o;
    logic       frame_err_o;

    modport master (
        output rx_i,
        output sample_tick_i,
        input  dout_o,
        input  rx_done_tick_o,
        input  frame_err_o
    );

    modport slave (
        input  rx_i,
        input  sample_tick_i,
        output dout_o,
        output rx_done_tick_o,
        output frame_err_o
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: mid-bit sampling of start/data/stop, one-cycle done pulse
// with the right-justified word and a framing-error flag.
module uart_rx #(
    parameter int WordLength   = 8,
    parameter int StopBitTicks = 16
) (
    input logic      clk_i,
    input logic      rst_i,
    uart_rx_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [4:0] MidStart = 5'd7;
    localparam logic [4:0] BitLast  = 5'd15;
    localparam logic [4:0] StopLast = 5'(StopBitTicks - 1);
    localparam logic [2:0] LastBit  = 3'(WordLength - 1);
    localparam int         Pad      = 8 - WordLength;

    logic       rx_meta;
    logic       rx_sync;
    logic       rx_prev;
    logic [1:0] state;
    logic [4:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       stop_bit;
    logic       stop_hit;
    logic [7:0] dout;
    logic       done;
    logic       ferr;

    // Bits shift in from the top, so a short word ends up left-justified and must be moved down.
    function automatic logic [7:0] justify(input logic [7:0] s);
        return s >> Pad;
    endfunction

    assign bus.dout_o         = dout;
    assign bus.rx_done_tick_o = done;
    assign bus.frame_err_o    = ferr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            tick_cnt <= 5'd0;
            bit_cnt  <= 3'd0;
            stop_hit <= 1'b0;
            dout     <= 8'h00;
            done     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            done     <= 1'b0;
            stop_hit <= 1'b0;
            if (stop_hit) begin
                dout <= justify(shift_reg);
                ferr <= ~stop_bit;
                done <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // Edge-triggered arming keeps a held-low (break) line from re-arming.
                    if (rx_prev && !rx_sync) begin
                        tick_cnt <= 5'd0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bus.sample_tick_i) begin
                        if (tick_cnt == MidStart) begin
                            if (!rx_sync) begin
                                state    <= DATA;
                                tick_cnt <= 5'd0;
                                bit_cnt  <= 3'd0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (bus.sample_tick_i) begin
                        if (tick_cnt == BitLast) begin
                            tick_cnt <= 5'd0;
                            if (bit_cnt == LastBit) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    if (bus.sample_tick_i) begin
                        if (tick_cnt == StopLast) begin
                            stop_hit <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Datapath registers carry no reset; they are only observed through the reset outputs.
    always_ff @(posedge clk_i) begin
        if (bus.sample_tick_i) begin
            if (state == DATA && tick_cnt == BitLast) begin
                shift_reg <= {rx_sync, shift_reg[7:1]};
            end
            if (state == STOP && tick_cnt == StopLast) begin
                stop_bit <= rx_sync;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three configurations (8N1, 8N2, 7N1) driven from one serial line generator.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       tick = 1'b0;
    logic [1:0] div = 2'd0;
    int         tick_cnt = 0;
    logic       rx_drv = 1'b1;
    int         sel = 0;

    always @(negedge clk) begin
        div  <= div + 2'd1;
        tick <= (div == 2'd3);
    end
    always @(posedge clk) if (tick) tick_cnt <= tick_cnt + 1;

    uart_rx_if ifc0 ();
    uart_rx_if ifc1 ();
    uart_rx_if ifc2 ();
    assign ifc0.sample_tick_i = tick;
    assign ifc1.sample_tick_i = tick;
    assign ifc2.sample_tick_i = tick;
    assign ifc0.rx_i = (sel == 0) ? rx_drv : 1'b1;
    assign ifc1.rx_i = (sel == 1) ? rx_drv : 1'b1;
    assign ifc2.rx_i = (sel == 2) ? rx_drv : 1'b1;

    uart_rx #(.WordLength(8), .StopBitTicks(16)) dut0 (.clk_i(clk), .rst_i(rst), .bus(ifc0));
    uart_rx #(.WordLength(8), .StopBitTicks(32)) dut1 (.clk_i(clk), .rst_i(rst), .bus(ifc1));
    uart_rx #(.WordLength(7), .StopBitTicks(16)) dut2 (.clk_i(clk), .rst_i(rst), .bus(ifc2));

    typedef struct {
        logic [7:0] word;
        logic       err;
        int         tk;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];
    logic [2:0] done_prev = 3'b000;
    int   wide_cnt = 0;

    always @(negedge clk) begin
        obs_t o;
        if (ifc0.rx_done_tick_o) begin o.word = ifc0.dout_o; o.err = ifc0.frame_err_o; o.tk = tick_cnt; q0.push_back(o); end
        if (ifc1.rx_done_tick_o) begin o.word = ifc1.dout_o; o.err = ifc1.frame_err_o; o.tk = tick_cnt; q1.push_back(o); end
        if (ifc2.rx_done_tick_o) begin o.word = ifc2.dout_o; o.err = ifc2.frame_err_o; o.tk = tick_cnt; q2.push_back(o); end
        if (done_prev[0] && ifc0.rx_done_tick_o) wide_cnt++;
        if (done_prev[1] && ifc1.rx_done_tick_o) wide_cnt++;
        if (done_prev[2] && ifc2.rx_done_tick_o) wide_cnt++;
        done_prev <= {ifc2.rx_done_tick_o, ifc1.rx_done_tick_o, ifc0.rx_done_tick_o};
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic obs_t qpop(input int d);
        case (d)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic wait_ticks(input int n);
        int target;
        target = tick_cnt + n;
        while (tick_cnt < target) @(negedge clk);
    endtask

    // Drives one frame; k0 is the tick index at which the start bit began.
    task automatic send_frame(input int d, input logic [7:0] data, input int nbits,
                              input logic stop_lvl, input int stop_ticks, output int k0);
        sel    = d;
        k0     = tick_cnt;
        rx_drv = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            rx_drv = data[i];
            wait_ticks(16);
        end
        rx_drv = stop_lvl;
        wait_ticks(stop_ticks);
    endtask

    task automatic expect_frame(input int d, input logic [7:0] w, input logic e, input int tk);
        obs_t o;
        int   n;
        n = qsize(d);
        chk($sformatf("pulse_count[dut%0d]", d), n, 1);
        if (n > 0) begin
            o = qpop(d);
            chk($sformatf("dout[dut%0d]", d), o.word, w);
            chk($sformatf("frame_err[dut%0d]", d), o.err, e);
            if (tk >= 0) chk($sformatf("pulse_tick[dut%0d]", d), o.tk, tk);
        end
        while (qsize(d) > 0) void'(qpop(d));
    endtask

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         nbits;
        logic       stop_lvl;
        int         stop_ticks;
        int         gap;
        logic [7:0] exp_word;
        logic       exp_err;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        int d;
        int nb;
        int st;
        int gap;
        logic [7:0] data;
        logic [7:0] mask;
        logic ok;

        tbl[0]  = '{0, 8'hA5, 8, 1'b1, 16, 1, 8'hA5, 1'b0};
        tbl[1]  = '{0, 8'h3C, 8, 1'b0, 16, 1, 8'h3C, 1'b1};
        tbl[2]  = '{0, 8'h55, 8, 1'b1, 16, 1, 8'h55, 1'b0};
        tbl[3]  = '{0, 8'h00, 8, 1'b1, 16, 0, 8'h00, 1'b0};
        tbl[4]  = '{0, 8'hFF, 8, 1'b1, 16, 0, 8'hFF, 1'b0};
        tbl[5]  = '{0, 8'h81, 8, 1'b1, 16, 1, 8'h81, 1'b0};
        tbl[6]  = '{1, 8'h00, 8, 1'b1, 32, 0, 8'h00, 1'b0};
        tbl[7]  = '{1, 8'hFF, 8, 1'b1, 32, 0, 8'hFF, 1'b0};
        tbl[8]  = '{1, 8'h81, 8, 1'b1, 32, 1, 8'h81, 1'b0};
        tbl[9]  = '{2, 8'h7F, 7, 1'b1, 16, 1, 8'h7F, 1'b0};
        tbl[10] = '{2, 8'hD5, 7, 1'b1, 16, 1, 8'h55, 1'b0};

        rst    = 1'b1;
        rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dout", {ifc0.dout_o, ifc1.dout_o, ifc2.dout_o}, 24'h0);
        chk("reset_done", {ifc0.rx_done_tick_o, ifc1.rx_done_tick_o, ifc2.rx_done_tick_o}, 3'b000);
        chk("reset_ferr", {ifc0.frame_err_o, ifc1.frame_err_o, ifc2.frame_err_o}, 3'b000);
        rst = 1'b0;
        wait_ticks(4);

        for (int i = 0; i < 11; i++) begin
            send_frame(tbl[i].dut, tbl[i].data, tbl[i].nbits, tbl[i].stop_lvl, tbl[i].stop_ticks, k0);
            expect_frame(tbl[i].dut, tbl[i].exp_word, tbl[i].exp_err,
                         k0 + 8 + 16 * tbl[i].nbits + tbl[i].stop_ticks);
            rx_drv = 1'b1;
            wait_ticks(16 * tbl[i].gap);
        end

        // Short low glitch must not produce a frame or disturb the held word.
        sel    = 0;
        rx_drv = 1'b0;
        wait_ticks(4);
        rx_drv = 1'b1;
        wait_ticks(20);
        chk("glitch_no_pulse", qsize(0), 0);
        chk("glitch_dout_held", ifc0.dout_o, 8'h81);
        chk("glitch_ferr_held", ifc0.frame_err_o, 1'b0);

        // Break: line held low for three frame times arms exactly once.
        sel    = 0;
        k0     = tick_cnt;
        rx_drv = 1'b0;
        wait_ticks(3 * 160);
        expect_frame(0, 8'h00, 1'b1, k0 + 152);
        rx_drv = 1'b1;
        wait_ticks(16);
        send_frame(0, 8'h55, 8, 1'b1, 16, k0);
        expect_frame(0, 8'h55, 1'b0, k0 + 152);
        send_frame(0, 8'h96, 8, 1'b0, 16, k0);
        expect_frame(0, 8'h96, 1'b1, k0 + 152);
        rx_drv = 1'b1;
        wait_ticks(16);

        // Reset in the middle of data bit 3.
        sel    = 0;
        rx_drv = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx_drv = ~rx_drv;
            wait_ticks(16);
        end
        wait_ticks(4);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_dout", ifc0.dout_o, 8'h00);
        chk("midreset_ferr", ifc0.frame_err_o, 1'b0);
        chk("midreset_done", ifc0.rx_done_tick_o, 1'b0);
        rst    = 1'b0;
        rx_drv = 1'b1;
        wait_ticks(200);
        chk("midreset_no_pulse", qsize(0), 0);

        for (int i = 0; i < 24; i++) begin
            d    = $urandom_range(0, 2);
            data = 8'($urandom);
            ok   = ($urandom_range(0, 4) != 0);
            gap  = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
            nb   = (d == 2) ? 7 : 8;
            st   = (d == 1) ? 32 : 16;
            mask = 8'((1 << nb) - 1);
            send_frame(d, data, nb, ok, st, k0);
            expect_frame(d, data & mask, ~ok, k0 + 8 + 16 * nb + st);
            rx_drv = 1'b1;
            wait_ticks(16 * gap);
        end

        wait_ticks(40);
        chk("stray_pulses", qsize(0) + qsize(1) + qsize(2), 0);
        chk("pulse_width", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
